uart_transmitter: RTL and testbench
===================================

# uart_transmitter

Serial UART transmitter, the send-side counterpart of the 9600-baud, 8N1 receiver already in the design. It accepts bytes from the arm-control logic through a single-cycle strobe interface, buffers up to FIFO_DEPTH bytes, and shifts each byte out on TxD as 1 start bit, 8 data bits LSB first, and 1 stop bit. It sits at the FPGA top level, driving the UART TX pin toward the host or companion board.

## Interface
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 9_600: serial bit rate.
- DIV_BIT, CLK_FREQ/BAUD_RATE (10416): clocks per serial bit; must be ≥ 2.
- FIFO_DEPTH, 4: byte buffer depth; power of two, ≥ 2.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- send  input  1  write strobe; the byte is accepted on any cycle where send=1 and ready=1.
- TxData  input  8  byte to transmit; sampled only on an accepted write.
- TxD  output  1  serial line; idles high.
- ready  output  1  FIFO not full.
- busy  output  1  FIFO non-empty or a frame in progress.
- done  output  1  one-cycle pulse on the last clock of each stop bit.
- ovf  output  1  one-cycle pulse when send=1 while ready=0.

## Operation
- Reset (rst=0, asynchronous): FSM to IDLE; FIFO empty; counters cleared. Outputs: TxD=1, ready=1, busy=0, done=0, ovf=0. An in-flight frame is abandoned and the line returns high immediately.
- FIFO write:
  - An accepted write stores TxData at the write pointer and increments the count.
  - A write while full is dropped: no state change, and ovf pulses for that cycle.
- FSM states:
  - **IDLE**: TxD=1. If the FIFO is non-empty, pop the head into shift register sh[7:0], clear the bit-timer and bitcnt, and go to START.
  - **START**: TxD=0 for DIV_BIT clocks, then go to DATA.
  - **DATA**: TxD=sh[0] for DIV_BIT clocks; at the end of each bit, shift sh right and increment bitcnt. After bitcnt reaches 7 and that bit's time expires, go to STOP.
  - **STOP**: TxD=1 for DIV_BIT clocks; done pulses on the final clock; return to IDLE.
- Bit timer:
  - Width $clog2(DIV_BIT).
  - Counts 0..DIV_BIT-1 and wraps to 0 at each bit boundary.
- FIFO count:
  - Width $clog2(FIFO_DEPTH)+1.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle leave the count unchanged.
- Flag definitions:
  - ready = (count != FIFO_DEPTH), registered from the post-update count.
  - busy = (count != 0) || (state != IDLE).
- TxD is driven from a flop, so the line never glitches.

## Timing
- Accepted write at edge N with the FIFO empty and FSM in IDLE:
  - The FIFO is non-empty after edge N.
  - The pop happens at edge N+1, and TxD falls after edge N+1.
  - Latency from the write edge to the start bit is 1 cycle.
- One frame is exactly 10·DIV_BIT clocks from the TxD falling edge to the end of the stop bit.
- Back-to-back bytes: after STOP, IDLE holds TxD=1 for exactly 1 clock before the next START. The inter-frame high time is therefore DIV_BIT+1 clocks.
- ready deasserts the cycle after the write that fills the FIFO. It reasserts the cycle after the pop that frees a slot.
- Simultaneous write and pop with the FIFO full: ready was 0, so the write is refused (ovf=1) and the pop proceeds.
- TxData changing after acceptance has no effect on the queued byte.

## Structure
- Shared package uart_pkg holds:
  - the tx_state_t enum (IDLE, START, DATA, STOP);
  - the UART_DATA_BITS=8 constant;
  - the default CLK_FREQ and BAUD_RATE, shared with the receiver.
- Sub-module uart_tx_fifo: synchronous FIFO with push/pop/full/empty/count and the same asynchronous active-low rst. The FSM, bit timer and shift register stay in uart_transmitter.

## Test plan
All scenarios use CLK_FREQ=16 and BAUD_RATE=1, giving DIV_BIT=16.
- Reset mid-frame: rst low during DATA bit 3 → TxD=1, busy=0, ready=1 in the same cycle. No further frame is sent after release.
- Single byte 0xA5 written while idle:
  - TxD falls 1 clk after the write and stays low for 16 clks.
  - Data bits follow LSB first, 1,0,1,0,0,1,0,1, at 16 clks each.
  - The stop bit is high for 16 clks; done pulses once at clock 160 of the frame.
- Burst of 0x00, 0xFF, 0x55, 0x3C on consecutive cycles: ready drops after the 4th write. Four frames go out in order, separated by exactly 17 high clks.
- Fifth write while full: ovf pulses for 1 clk and the byte is dropped. Only 4 frames are observed.
- Write landing on the pop cycle with 3 entries queued: accepted (count stays 3), then transmitted fifth.
- Loopback of TxD into the receiver for 0x00..0xFF: every receiver RxData equals the sent byte.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_pkg : constants and state type shared by the UART blocks     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_CLK_FREQ  = 100_000_000;
  localparam int UART_BAUD_RATE = 9_600;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_transmitter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_transmitter_if : byte strobe interface and TX line/status    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface uart_transmitter_if;

  logic       send;
  logic [7:0] TxData;
  logic       TxD;
  logic       ready;
  logic       busy;
  logic       done;
  logic       ovf;

  modport master (
    output send,
    output TxData,
    input  TxD,
    input  ready,
    input  busy,
    input  done,
    input  ovf
  );

  modport slave (
    input  send,
    input  TxData,
    output TxD,
    output ready,
    output busy,
    output done,
    output ovf
  );

endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_tx_fifo : synchronous byte FIFO, async active-low reset      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       i_push,
  input  wire logic [WIDTH-1:0]           i_data,
  input  wire logic                       i_pop,
  output      logic [WIDTH-1:0]           o_data,
  output      logic                       o_full,
  output      logic                       o_empty,
  output      logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;

  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_next;

  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop && (r_count != '0);

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - CNT_W'(1);
    end
  end

  // Full flag is registered from the post-update count so it is a clean flop output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/uart_transmitter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_transmitter : FIFO-buffered 8N1 serial transmitter           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = UART_CLK_FREQ,
  parameter int BAUD_RATE  = UART_BAUD_RATE,
  parameter int DIV_BIT    = CLK_FREQ / BAUD_RATE,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  uart_transmitter_if.slave  bus
);

  localparam int TMR_W = $clog2(DIV_BIT);
  localparam int BCN_W = $clog2(UART_DATA_BITS);
  localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(DIV_BIT - 1);
  localparam logic [BCN_W-1:0] C_BIT_LAST = BCN_W'(UART_DATA_BITS - 1);

  tx_state_t                  r_state;
  tx_state_t                  w_state_next;
  logic [TMR_W-1:0]           r_tmr;
  logic [TMR_W-1:0]           w_tmr_next;
  logic [BCN_W-1:0]           r_bitcnt;
  logic [BCN_W-1:0]           w_bitcnt_next;
  logic [UART_DATA_BITS-1:0]  r_sh;
  logic [UART_DATA_BITS-1:0]  w_sh_next;
  logic                       r_txd;
  logic                       w_txd_next;

  logic                       w_bit_end;
  logic                       w_pop;
  logic                       w_full;
  logic                       w_empty;
  logic [UART_DATA_BITS-1:0]  w_fifo_data;
  logic [$clog2(FIFO_DEPTH):0] w_count;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.send),
    .i_data  (bus.TxData),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_bit_end = (r_tmr == C_TMR_LAST);

  always_comb begin
    w_state_next  = r_state;
    w_tmr_next    = w_bit_end ? '0 : r_tmr + TMR_W'(1);
    w_bitcnt_next = r_bitcnt;
    w_sh_next     = r_sh;
    w_pop         = 1'b0;
    case (r_state)
      IDLE: begin
        w_tmr_next = '0;
        if (!w_empty) begin
          w_pop         = 1'b1;
          w_sh_next     = w_fifo_data;
          w_bitcnt_next = '0;
          w_state_next  = START;
        end
      end
      START: begin
        if (w_bit_end) w_state_next = DATA;
      end
      DATA: begin
        if (w_bit_end) begin
          w_sh_next     = r_sh >> 1;
          w_bitcnt_next = r_bitcnt + BCN_W'(1);
          if (r_bitcnt == C_BIT_LAST) w_state_next = STOP;
        end
      end
      STOP: begin
        if (w_bit_end) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase

    // Line level follows the state being entered so TxD stays aligned with the FSM.
    case (w_state_next)
      START:   w_txd_next = 1'b0;
      DATA:    w_txd_next = w_sh_next[0];
      default: w_txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_tmr    <= '0;
      r_bitcnt <= '0;
      r_sh     <= '0;
      r_txd    <= 1'b1;
    end else begin
      r_state  <= w_state_next;
      r_tmr    <= w_tmr_next;
      r_bitcnt <= w_bitcnt_next;
      r_sh     <= w_sh_next;
      r_txd    <= w_txd_next;
    end
  end

  assign bus.TxD   = r_txd;
  assign bus.ready = !w_full;
  assign bus.ovf   = bus.send && w_full;
  assign bus.busy  = (w_count != '0) || (r_state != IDLE);
  assign bus.done  = (r_state == STOP) && w_bit_end;

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_uart_transmitter : directed + randomized bench with line decoder|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_uart_transmitter;

  localparam int DIV   = 16;
  localparam int FRAME = 10 * DIV;
  localparam int PITCH = FRAME + 1;

  typedef struct {
    logic [7:0] data;
    int         start;
    bit         shape_ok;
    int         done_idx;
    int         done_cnt;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_transmitter_if bus();

  uart_transmitter #(
    .CLK_FREQ   (16),
    .BAUD_RATE  (1),
    .DIV_BIT    (DIV),
    .FIFO_DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Line decoder: captures each frame from its falling edge, 160 samples.
  frame_t frames[$];
  logic   samp [FRAME];
  bit     mon_active = 1'b0;
  int     mon_idx, mon_start, mon_done_idx, mon_done_cnt;
  int     stray_done = 0;

  always @(negedge clk) begin
    if (!rst) begin
      mon_active = 1'b0;
    end else begin
      if (!mon_active && bus.TxD === 1'b0) begin
        mon_active   = 1'b1;
        mon_idx      = 0;
        mon_start    = cyc;
        mon_done_idx = -1;
        mon_done_cnt = 0;
      end
      if (mon_active) begin
        samp[mon_idx] = bus.TxD;
        if (bus.done === 1'b1) begin
          mon_done_cnt++;
          mon_done_idx = mon_idx;
        end
        mon_idx++;
        if (mon_idx == FRAME) begin
          frame_t f;
          logic   lvl;
          f.shape_ok = 1'b1;
          for (int b = 0; b < 10; b++) begin
            lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : samp[b*DIV + DIV/2];
            for (int s = 0; s < DIV; s++)
              if (samp[b*DIV + s] !== lvl) f.shape_ok = 1'b0;
          end
          for (int k = 0; k < 8; k++) f.data[k] = samp[(k+1)*DIV + DIV/2];
          f.start    = mon_start;
          f.done_idx = mon_done_idx;
          f.done_cnt = mon_done_cnt;
          frames.push_back(f);
          mon_active = 1'b0;
        end
      end else if (bus.done === 1'b1) begin
        stray_done++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t;
    t = 0;
    while (frames.size() < n && t < budget) begin
      step(1);
      t++;
    end
    chk("frame_wait", 32'(frames.size() >= n), 32'd1);
  endtask

  initial begin
    int         wcyc, s0, bad;
    logic [7:0] burst [4];
    logic [7:0] exp_order [6];
    logic [7:0] leader, extra;
    int         order [256];
    logic [7:0] exp_q [$];
    frame_t     f, prev;

    bus.send   = 1'b0;
    bus.TxData = 8'h00;
    rst        = 1'b0;
    step(3);
    chk("rst_txd",   32'(bus.TxD),   32'd1);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_busy",  32'(bus.busy),  32'd0);
    chk("rst_done",  32'(bus.done),  32'd0);
    chk("rst_ovf",   32'(bus.ovf),   32'd0);
    rst = 1'b1;
    step(2);

    // Single byte 0xA5 from idle
    bus.send = 1'b1; bus.TxData = 8'hA5;
    step(1);
    wcyc = cyc;
    bus.send = 1'b0; bus.TxData = 8'h5A;
    chk("a5_busy_after_write", 32'(bus.busy), 32'd1);
    chk("a5_txd_before_pop",   32'(bus.TxD),  32'd1);
    step(1);
    chk("a5_txd_start", 32'(bus.TxD), 32'd0);
    wait_frames(1, 400);
    if (frames.size() > 0) begin
      f = frames.pop_front();
      chk("a5_data",     32'(f.data),     32'hA5);
      chk("a5_shape",    32'(f.shape_ok), 32'd1);
      chk("a5_latency",  f.start - wcyc,  32'd1);
      chk("a5_done_idx", f.done_idx,      FRAME - 1);
      chk("a5_done_cnt", f.done_cnt,      32'd1);
    end
    step(3);
    chk("a5_idle_busy", 32'(bus.busy), 32'd0);

    // Reset during data bit 3
    bus.send = 1'b1; bus.TxData = 8'($urandom);
    step(1);
    bus.send = 1'b0;
    step(1 + DIV + 3*DIV + 5);
    rst = 1'b0;
    #1;
    chk("mid_rst_txd",   32'(bus.TxD),   32'd1);
    chk("mid_rst_busy",  32'(bus.busy),  32'd0);
    chk("mid_rst_ready", 32'(bus.ready), 32'd1);
    step(2);
    rst = 1'b1;
    step(2 * FRAME);
    chk("mid_rst_no_frame", frames.size(), 32'd0);
    chk("mid_rst_txd_idle", 32'(bus.TxD), 32'd1);

    // Leader frame occupies the FSM, then a 4-byte burst fills the FIFO
    leader   = 8'($urandom);
    burst[0] = 8'h00; burst[1] = 8'hFF; burst[2] = 8'h55; burst[3] = 8'h3C;
    bus.send = 1'b1; bus.TxData = leader;
    step(1);
    s0 = cyc + 1;
    bus.send = 1'b0;
    step(1);
    for (int i = 0; i < 4; i++) begin
      bus.send = 1'b1; bus.TxData = burst[i];
      step(1);
      chk($sformatf("burst_ready_%0d", i), 32'(bus.ready), 32'(i < 3));
    end
    bus.TxData = 8'hEE;
    #1;
    chk("full_ovf", 32'(bus.ovf), 32'd1);
    step(1);
    bus.send = 1'b0;
    #1;
    chk("full_ovf_clear",  32'(bus.ovf),   32'd0);
    chk("full_ready_held", 32'(bus.ready), 32'd0);

    // Slot frees on the pop at the start of burst frame 0
    while (cyc < s0 + PITCH - 1) step(1);
    chk("ready_before_pop", 32'(bus.ready), 32'd0);
    step(1);
    chk("ready_after_pop", 32'(bus.ready), 32'd1);

    // Write lands on the pop cycle with 3 entries queued
    while (cyc < s0 + 2*PITCH - 1) step(1);
    extra = 8'($urandom);
    bus.send = 1'b1; bus.TxData = extra;
    step(1);
    bus.send = 1'b0;
    chk("popwrite_ready", 32'(bus.ready), 32'd1);
    chk("popwrite_ovf",   32'(bus.ovf),   32'd0);
    chk("popwrite_txd",   32'(bus.TxD),   32'd0);

    exp_order[0] = leader;
    for (int i = 0; i < 4; i++) exp_order[i+1] = burst[i];
    exp_order[5] = extra;
    wait_frames(6, 6*PITCH + 400);
    for (int i = 0; i < 6 && frames.size() > 0; i++) begin
      f = frames.pop_front();
      chk($sformatf("burst_data_%0d", i), 32'(f.data), 32'(exp_order[i]));
      chk($sformatf("burst_shape_%0d", i), 32'(f.shape_ok && f.done_cnt == 1 && f.done_idx == FRAME-1), 32'd1);
      if (i > 0) chk($sformatf("burst_pitch_%0d", i), f.start - prev.start, PITCH);
      prev = f;
    end
    chk("burst_extra_frames", frames.size(), 32'd0);

    // Loopback of every byte value, random order and spacing, with overflow probes
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j, tmp;
      j = $urandom_range(0, i);
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      int t;
      step($urandom_range(0, 2) + 1);
      if (!bus.ready && $urandom_range(0, 3) == 0) begin
        bus.send = 1'b1; bus.TxData = 8'($urandom);
        #1;
        chk("probe_ovf", 32'(bus.ovf), 32'd1);
        step(1);
        bus.send = 1'b0;
      end
      t = 0;
      while (!bus.ready && t < 4 * PITCH) begin
        step(1);
        t++;
      end
      chk("loop_ready_wait", 32'(bus.ready), 32'd1);
      bus.send = 1'b1; bus.TxData = 8'(order[i]);
      exp_q.push_back(8'(order[i]));
      step(1);
      bus.send = 1'b0;
    end
    wait_frames(256, 256 * PITCH + 2000);
    bad = 0;
    while (frames.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] e;
      f = frames.pop_front();
      e = exp_q.pop_front();
      chk($sformatf("loop_data_%0h", e), 32'(f.data), 32'(e));
      if (!(f.shape_ok && f.done_cnt == 1 && f.done_idx == FRAME-1)) bad++;
    end
    chk("loop_shape_bad", bad, 32'd0);
    chk("loop_leftover_frames", frames.size(), 32'd0);
    step(5);
    chk("end_busy", 32'(bus.busy), 32'd0);
    chk("stray_done", stray_done, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
